// File: rtl/sub_ser4.sv
// Bit-serial unsigned subtractor: diff = a - b - bin, one bit per clock, LSB first.
// State | meaning
// IDLE  | waiting for start; diff/bout hold the last completed result
// RUN   | one full-subtractor step per clock, WIDTH steps in total
module sub_ser4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             load, step, last;
  logic             d_bit, br_nxt;

  // Single full-subtractor cell on the operand LSBs
  assign d_bit  = a_sh[0] ^ b_sh[0] ^ br;
  assign br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= last;
      if (load) begin
        a_sh   <= a;
        b_sh   <= b;
        br     <= bin;
        res_sh <= '0;
        cnt    <= '0;
      end else if (step) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        br     <= br_nxt;
        res_sh <= {d_bit, res_sh[WIDTH-1:1]};
        cnt    <= cnt + CW'(1);
      end
      // Outputs only move at completion; partial results stay in res_sh
      if (last) begin
        diff <= {d_bit, res_sh[WIDTH-1:1]};
        bout <= br_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sub_ser4.sv
// Directed bench for sub_ser4: scoreboard of expected {bout, diff} per accepted start.
module tb_sub_ser4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start, bin;
  logic [W-1:0] a, b;
  logic         busy, done, bout;
  logic [W-1:0] diff;

  int tests = 0;
  int fails = 0;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  sub_ser4 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive a request (sampled on the next edge) and push its expected result
  task automatic drive(input int av, input int bv, input int biv);
    int full;
    logic [31:0] fv;
    a     = av[W-1:0];
    b     = bv[W-1:0];
    bin   = biv[0];
    start = 1'b1;
    full  = av - bv - biv;
    fv    = full;
    exp_q.push_back({(av < bv + biv) ? 1'b1 : 1'b0, fv[W-1:0]});
  endtask

  // Called after the accepting edge has passed (plus lat0 further edges)
  task automatic wait_done(input string tag, input int lat0);
    int lat;
    int bc;
    logic [W:0] e;
    lat = lat0;
    bc  = lat0 + ((busy === 1'b1) ? 1 : 0);
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
      if (busy === 1'b1) bc++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_latency"}, lat, W);
    chk({tag, "_busy_cycles"}, bc, W);
    chk({tag, "_busy_low_at_done"}, busy, 0);
    chk({tag, "_queue"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_diff"}, diff, e[W-1:0]);
      chk({tag, "_bout"}, bout, e[W]);
    end
  endtask

  task automatic run(input string tag, input int av, input int bv, input int biv);
    drive(av, bv, biv);
    tick();
    start = 1'b0;
    a     = ~a;
    b     = ~b;
    wait_done(tag, 0);
  endtask

  initial begin
    int seen;
    int idx, av, bv, biv;
    logic [W-1:0] hold_d;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_diff", diff, 0);
    chk("reset_bout", bout, 0);

    run("op_11_1", 11, 1, 0);
    tick();
    chk("done_one_cycle", done, 0);
    chk("diff_hold", diff, 10);

    // Back-to-back: each new start issued in the done cycle
    drive(8, 2, 0);
    tick(); start = 1'b0;
    wait_done("seq_8_2", 0);
    drive(14, 7, 0);
    tick(); start = 1'b0;
    wait_done("seq_14_7", 0);
    drive(8, 3, 0);
    tick(); start = 1'b0;
    wait_done("seq_8_3", 0);

    run("uf_3_5", 3, 5, 0);
    run("uf_0_15_1", 0, 15, 1);
    run("uf_15_15_1", 15, 15, 1);
    tick();

    // Start while busy is ignored
    drive(9, 4, 0);
    tick(); start = 1'b0;
    tick();
    a = 4'd1; b = 4'd1; bin = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    wait_done("busy_start", 2);
    tick();
    chk("busy_start_not_queued", busy, 0);
    chk("busy_start_done_low", done, 0);

    // Reset mid-operation
    drive(12, 3, 0);
    tick(); start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_diff", diff, 0);
    chk("rst_mid_bout", bout, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    chk("rst_mid_no_done", seen, 0);
    run("after_rst_12_3", 12, 3, 0);
    hold_d = diff;
    tick();
    chk("after_rst_hold", diff, hold_d);

    // Exhaustive sweep in permuted order, back-to-back
    for (int i = 0; i < 512; i++) begin
      idx = (i * 197) % 512;
      av  = idx & 15;
      bv  = (idx >> 4) & 15;
      biv = (idx >> 8) & 1;
      drive(av, bv, biv);
      tick(); start = 1'b0;
      a = $urandom_range(15, 0);
      b = $urandom_range(15, 0);
      bin = $urandom_range(1, 0);
      wait_done("sweep", 0);
      chk("sweep_identity", int'(diff) + bv + biv, av + 16 * int'(bout));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
